banked_mem_responder: RTL and testbench
=======================================

Name: banked_mem_responder

Overview:
- Parametrised, synthesizable memory responder for the banked memory interface: the cache-side slave model used by benches and FPGA bring-up.
- Accepts line reads and multi-beat line writes, queues up to QDEPTH reads, and returns each read as a BURST-beat response after a programmable minimum latency.
- Holds a backing line store and flags protocol violations on a sticky error output.
- Sits between the DUT's cache/arbiter memory port and nothing else.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 64, beat width in bits.
- BURST, 4, beats per line transfer.
- QDEPTH, 4, outstanding read queue depth (power of 2, ≥2).
- LATENCY, 8, minimum cycles from read acceptance to first rdata beat (≥1).
- LINES, 256, backing store depth in lines (power of 2); index = addr[log2(LINE_BYTES)+:log2(LINES)], where LINE_BYTES = DATA_W/8*BURST.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  request line address, sampled on the accepted read or on the first write beat.
- read  in  1  read request, one cycle.
- write  in  1  write beat valid.
- wdata  in  DATA_W  write beat data.
- ready  out  1  new request may be accepted this cycle.
- raddr  out  ADDR_W  address of the line being returned.
- rdata  out  DATA_W  read beat data.
- rvalid  out  1  rdata/raddr valid.
- error  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: ready=0 on the cycle rst is high, 1 thereafter; rvalid=0, rdata=0, raddr=0, error=0; queue emptied; burst counters cleared. Backing store contents are not reset.
- Reset mid-burst: in-flight read responses and partial writes are discarded; no further beats are driven.
- ready = !queue_full && !wr_collecting.
- Read accept (read && ready):
  - push {addr, age=0} into the queue.
  - Each entry's age increments every cycle, saturating at LATENCY.
- Write accept (write && ready && !wr_collecting):
  - beat 0 is stored; the state machine moves to WR_COLLECT with a beat counter.
  - Beats 1..BURST-1 must arrive on consecutive cycles with write=1 and are accepted regardless of ready.
  - On the last beat the full line is committed to the store, at the index from the captured addr.
  - ready returns to 1 the next cycle.
- Write FSM: WR_IDLE -> WR_COLLECT on the first beat; WR_COLLECT -> WR_IDLE after BURST beats.
- A write is visible to any read accepted after its final beat.
- Read response FSM:
  - RD_IDLE -> RD_BURST when the queue is non-empty and head age == LATENCY.
  - In RD_BURST, drive rvalid=1, raddr=head.addr, and rdata=store[line][beat] for beats 0..BURST-1, low beat first, on consecutive cycles.
  - After the last beat, pop the head. If the next head has age == LATENCY, the next burst starts on the immediately following cycle (no bubble); otherwise return to RD_IDLE.
- Responses are strictly in acceptance order. First beat appears exactly LATENCY cycles after acceptance when the responder is idle.
- Simultaneous push and pop in the same cycle is legal. ready is computed from occupancy before the pop, so a full queue deasserts ready even in the pop cycle.
- error is set (sticky until rst) on any of the following:
  - read && write in the same cycle;
  - read or first write beat with addr[log2(LINE_BYTES)-1:0] != 0;
  - read or write asserted while ready=0 and not collecting;
  - write deasserted before BURST beats complete, which also aborts the collection and discards the line;
  - read asserted during WR_COLLECT.
- Erroneous requests are not enqueued or committed.

Test Plan:
- Single read: read at addr 0x40 with idle responder, LATENCY=8 → rvalid high on cycles 8..11 after acceptance, raddr=0x40, 4 beats of store line 2, error=0.
- Write then read: 4-beat write to 0x80 with wdata 0x11..,0x22..,0x33..,0x44..; then read 0x80 → beats return 0x11..,0x22..,0x33..,0x44.. in order.
- Queue full: 4 reads on consecutive cycles → ready=0 after the 4th; responses are 16 back-to-back rvalid cycles with no bubble; ready=1 the cycle after the first pop.
- Protocol errors: read at 0x44, or read&&write together, or write dropped after 2 beats → error=1 and stays 1; no response or commit for the bad request.
- Reset mid-burst: assert rst during beat 2 of a response → rvalid=0 immediately; after release, ready=1, no stale beats, and a prior committed line still reads back correctly.
- Parameter sweep: DATA_W=32, BURST=8, LATENCY=1 → first beat arrives 1 cycle after acceptance; 8 beats are returned; addresses must be 32-byte aligned.

Source files
------------

// File: rtl/banked_mem_responder.sv
// Cache-side memory slave: queues line reads, returns them as BURST-beat responses after
// LATENCY cycles, collects multi-beat line writes into a backing store, flags protocol misuse.
module banked_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BURST   = 4,
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 8,
  parameter int LINES   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              error
);

  localparam int LINE_BYTES = DATA_W / 8 * BURST;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(LINES);
  localparam int PTR_W      = $clog2(QDEPTH);
  localparam int CNT_W      = $clog2(QDEPTH + 1);
  localparam int BEAT_W     = $clog2(BURST);
  localparam int AGE_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit LAT1       = (LATENCY == 1);
  localparam logic [AGE_W-1:0] AGE_DUE  = AGE_W'(LATENCY - 1);
  localparam logic [AGE_W-1:0] AGE_PUSH = AGE_W'(LAT1 ? 0 : 1);

  // WR_IDLE | waiting for a first write beat    WR_COLLECT | gathering beats 1..BURST-1
  // RD_IDLE | no response on the bus            RD_BURST   | driving beats of the queue head
  typedef enum logic {WR_IDLE, WR_COLLECT} wr_state_t;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [BURST-1:0][DATA_W-1:0] mem [LINES];
  logic [BURST-1:0][DATA_W-1:0] wline, commit_line;
  logic [IDX_W-1:0]  wr_idx, head_idx;
  logic [BEAT_W-1:0] wbeat, rbeat;

  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [AGE_W-1:0]  q_age  [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, next_ptr;
  logic [CNT_W-1:0]  count;

  logic out_of_reset, wr_collecting, misaligned, full;
  logic push, wr_first, wr_last, last_beat, head_due, next_due, err_now;

  assign wr_collecting = (wr_state == WR_COLLECT);
  assign misaligned    = |addr[OFF_W-1:0];
  assign full          = (count == CNT_W'(QDEPTH));
  assign ready         = out_of_reset && !full && !wr_collecting;

  assign push     = read && !write && ready && !misaligned;
  assign wr_first = write && !read && ready && !misaligned;
  assign wr_last  = wr_collecting && write && (wbeat == BEAT_W'(BURST - 1));

  assign err_now = (read && write)
                || (read && misaligned)
                || (write && !wr_collecting && misaligned)
                || ((read || write) && !ready && !wr_collecting)
                || (wr_collecting && (read || !write));

  // Ages count cycles since acceptance and park at LATENCY-1, the cycle a burst is scheduled.
  assign next_ptr  = rd_ptr + PTR_W'(1);
  assign head_due  = (count != '0) && (q_age[rd_ptr] == AGE_DUE);
  assign next_due  = (count > CNT_W'(1)) ? (q_age[next_ptr] == AGE_DUE) : (LAT1 && push);
  assign last_beat = (rd_state == RD_BURST) && (rbeat == BEAT_W'(BURST - 1));
  assign head_idx  = q_addr[rd_ptr][OFF_W +: IDX_W];

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:    if (wr_first) wr_next = WR_COLLECT;
      WR_COLLECT: if (!write || wr_last) wr_next = WR_IDLE;
      default:    wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:  if (head_due || (LAT1 && count == '0 && push)) rd_next = RD_BURST;
      RD_BURST: if (last_beat && !next_due) rd_next = RD_IDLE;
      default:  rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    commit_line          = wline;
    commit_line[BURST-1] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state     <= WR_IDLE;
      rd_state     <= RD_IDLE;
      out_of_reset <= 1'b0;
      error        <= 1'b0;
      wbeat        <= '0;
      wr_idx       <= '0;
      rbeat        <= '0;
    end else begin
      wr_state     <= wr_next;
      rd_state     <= rd_next;
      out_of_reset <= 1'b1;
      if (err_now) error <= 1'b1;
      if (wr_first) begin
        wbeat  <= BEAT_W'(1);
        wr_idx <= addr[OFF_W +: IDX_W];
      end else if (wr_collecting && write) begin
        wbeat <= wbeat + BEAT_W'(1);
      end
      if (rd_state == RD_BURST) rbeat <= last_beat ? '0 : rbeat + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr[i] <= '0;
        q_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++)
        if (q_age[i] != AGE_DUE) q_age[i] <= q_age[i] + AGE_W'(1);
      if (push) begin
        q_addr[wr_ptr] <= addr;
        q_age[wr_ptr]  <= AGE_PUSH;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (last_beat) rd_ptr <= next_ptr;
      case ({push, last_beat})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Line buffer and store are not reset; a reset only drops the write in progress.
  always_ff @(posedge clk) begin
    if (wr_first) wline[0] <= wdata;
    else if (wr_collecting && write) wline[wbeat] <= wdata;
    if (wr_last) mem[wr_idx] <= commit_line;
  end

  assign rvalid = (rd_state == RD_BURST);
  assign raddr  = rvalid ? q_addr[rd_ptr] : '0;
  assign rdata  = rvalid ? mem[head_idx][rbeat] : '0;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder: default instance plus a DATA_W=32/BURST=8/LATENCY=1 instance.
module tb_banked_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [63:0] wdata = '0;
  logic        ready, rvalid, error;
  logic [31:0] raddr;
  logic [63:0] rdata;

  logic [31:0] s_addr = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_wdata = '0;
  logic        s_ready, s_rvalid, s_error;
  logic [31:0] s_raddr;
  logic [31:0] s_rdata;

  int checks = 0;
  int failures = 0;

  logic [63:0] line_a [4] = '{64'hA0A0_0000_0000_0000, 64'hA1A1_0000_0000_0001,
                              64'hA2A2_0000_0000_0002, 64'hA3A3_0000_0000_0003};
  logic [63:0] line_w [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
  logic [63:0] line_d [4] = '{64'hD0D0_D0D0_0000_0000, 64'hD1D1_D1D1_0000_0001,
                              64'hD2D2_D2D2_0000_0002, 64'hD3D3_D3D3_0000_0003};
  logic [63:0] line_c [4] = '{64'hC0C0_0000_C0C0_0000, 64'hC1C1_0000_C1C1_0001,
                              64'hC2C2_0000_C2C2_0002, 64'hC3C3_0000_C3C3_0003};

  banked_mem_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .read(read), .write(write), .wdata(wdata),
    .ready(ready), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .error(error)
  );

  banked_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .BURST(8), .QDEPTH(4), .LATENCY(1), .LINES(256)
  ) dut_s (
    .clk(clk), .rst(rst), .addr(s_addr), .read(s_read), .write(s_write), .wdata(s_wdata),
    .ready(s_ready), .raddr(s_raddr), .rdata(s_rdata), .rvalid(s_rvalid), .error(s_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    read = 0; write = 0; s_read = 0; s_write = 0;
    rst = 1;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3);
    write = 1; addr = a;
    wdata = d0; step();
    wdata = d1; step();
    wdata = d2; step();
    wdata = d3; step();
    write = 0;
  endtask

  task automatic wait_rvalid(output bit seen);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rvalid) begin
        seen = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (raddr !== 32'h0) begin failures++; $display("FAIL rst_raddr got=%h exp=0", raddr); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    rst = 0;
    step();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", ready); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready_after got=%b exp=1", s_ready); end
  endtask

  task automatic test_single_read();
    logic exp_v;
    do_write(32'h40, line_a[0], line_a[1], line_a[2], line_a[3]);
    read = 1; addr = 32'h40;
    step();
    read = 0;
    for (int c = 1; c <= 12; c++) begin
      exp_v = (c >= 8 && c <= 11);
      checks++;
      if (rvalid !== exp_v) begin failures++; $display("FAIL single_rvalid cyc=%0d got=%b exp=%b", c, rvalid, exp_v); end
      if (exp_v) begin
        checks++;
        if (raddr !== 32'h40) begin failures++; $display("FAIL single_raddr cyc=%0d got=%h exp=40", c, raddr); end
        checks++;
        if (rdata !== line_a[c-8]) begin failures++; $display("FAIL single_rdata cyc=%0d got=%h exp=%h", c, rdata, line_a[c-8]); end
      end
      step();
    end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL single_error got=%b exp=0", error); end
  endtask

  task automatic test_write_read();
    bit seen;
    for (int b = 0; b < 4; b++) begin
      write = 1; addr = 32'h80; wdata = line_w[b];
      if (b == 1) begin
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL wr_ready_collect got=%b exp=0", ready); end
      end
      step();
    end
    write = 0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wr_ready_done got=%b exp=1", ready); end
    read = 1; addr = 32'h80;
    step();
    read = 0;
    wait_rvalid(seen);
    checks++; if (!seen) begin failures++; $display("FAIL wr_rd_timeout got=none exp=rvalid"); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== line_w[b] || raddr !== 32'h80) begin
        failures++;
        $display("FAIL wr_rd_beat%0d got=%b/%h/%h exp=1/%h/80", b, rvalid, rdata, raddr, line_w[b]);
      end
      step();
    end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL wr_rd_end got=%b exp=0", rvalid); end
  endtask

  task automatic test_queue_full();
    logic [31:0] qa [4] = '{32'h40, 32'h80, 32'h40, 32'h80};
    logic exp_v, exp_r;
    logic [63:0] exp_d;
    int k, b;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL qf_ready_pre%0d got=%b exp=1", i, ready); end
      read = 1; addr = qa[i];
      step();
    end
    read = 0;
    for (int c = 4; c <= 24; c++) begin
      exp_v = (c >= 8 && c <= 23);
      exp_r = (c >= 12);
      checks++;
      if (rvalid !== exp_v) begin failures++; $display("FAIL qf_rvalid cyc=%0d got=%b exp=%b", c, rvalid, exp_v); end
      checks++;
      if (ready !== exp_r) begin failures++; $display("FAIL qf_ready cyc=%0d got=%b exp=%b", c, ready, exp_r); end
      if (exp_v) begin
        k = (c - 8) / 4;
        b = (c - 8) % 4;
        exp_d = (k % 2 == 0) ? line_a[b] : line_w[b];
        checks++;
        if (rdata !== exp_d || raddr !== qa[k]) begin
          failures++;
          $display("FAIL qf_data cyc=%0d got=%h@%h exp=%h@%h", c, rdata, raddr, exp_d, qa[k]);
        end
      end
      step();
    end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL qf_error got=%b exp=0", error); end
  endtask

  task automatic test_protocol_errors();
    bit seen;
    int nv;
    do_reset();
    read = 1; addr = 32'h44;
    step();
    read = 0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_misaligned got=%b exp=1", error); end
    nv = 0;
    for (int i = 0; i < 20; i++) begin if (rvalid) nv++; step(); end
    checks++; if (nv != 0) begin failures++; $display("FAIL err_misaligned_resp got=%0d exp=0", nv); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", error); end

    do_reset();
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", error); end
    read = 1; write = 1; addr = 32'h40; wdata = 64'hBAD0;
    step();
    read = 0; write = 0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_rd_wr got=%b exp=1", error); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL err_rd_wr_ready got=%b exp=1", ready); end
    nv = 0;
    for (int i = 0; i < 20; i++) begin if (rvalid) nv++; step(); end
    checks++; if (nv != 0) begin failures++; $display("FAIL err_rd_wr_resp got=%0d exp=0", nv); end

    do_reset();
    do_write(32'h100, line_d[0], line_d[1], line_d[2], line_d[3]);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_good_write got=%b exp=0", error); end
    write = 1; addr = 32'h100; wdata = 64'hEEEE_0000;
    step();
    wdata = 64'hEEEE_0001;
    step();
    write = 0;
    step();
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_drop got=%b exp=1", error); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL err_drop_ready got=%b exp=1", ready); end
    read = 1; addr = 32'h100;
    step();
    read = 0;
    wait_rvalid(seen);
    checks++; if (!seen) begin failures++; $display("FAIL err_drop_timeout got=none exp=rvalid"); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== line_d[b]) begin
        failures++;
        $display("FAIL err_drop_beat%0d got=%b/%h exp=1/%h", b, rvalid, rdata, line_d[b]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    int nv;
    do_reset();
    do_write(32'hC0, line_c[0], line_c[1], line_c[2], line_c[3]);
    read = 1; addr = 32'hC0;
    step();
    read = 0;
    wait_rvalid(seen);
    checks++; if (!seen) begin failures++; $display("FAIL mid_timeout got=none exp=rvalid"); end
    step(); step();
    checks++; if (rdata !== line_c[2]) begin failures++; $display("FAIL mid_beat2 got=%h exp=%h", rdata, line_c[2]); end
    rst = 1;
    #1;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 64'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", ready); end
    step();
    rst = 0;
    step();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", ready); end
    nv = 0;
    for (int i = 0; i < 15; i++) begin if (rvalid) nv++; step(); end
    checks++; if (nv != 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", nv); end
    read = 1; addr = 32'h80;
    step();
    read = 0;
    wait_rvalid(seen);
    checks++; if (!seen) begin failures++; $display("FAIL mid_reread_timeout got=none exp=rvalid"); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== line_w[b]) begin
        failures++;
        $display("FAIL mid_reread_beat%0d got=%b/%h exp=1/%h", b, rvalid, rdata, line_w[b]);
      end
      step();
    end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL mid_error got=%b exp=0", error); end
  endtask

  task automatic test_param_sweep();
    logic exp_v;
    logic [31:0] exp_d;
    do_reset();
    for (int b = 0; b < 8; b++) begin
      s_write = 1; s_addr = 32'h20; s_wdata = 32'h5A00_0000 + b;
      step();
    end
    s_write = 0;
    s_read = 1; s_addr = 32'h20;
    step();
    s_read = 0;
    for (int c = 1; c <= 9; c++) begin
      exp_v = (c <= 8);
      checks++;
      if (s_rvalid !== exp_v) begin failures++; $display("FAIL sw_rvalid cyc=%0d got=%b exp=%b", c, s_rvalid, exp_v); end
      if (exp_v) begin
        exp_d = 32'h5A00_0000 + (c - 1);
        checks++;
        if (s_rdata !== exp_d || s_raddr !== 32'h20) begin
          failures++;
          $display("FAIL sw_data cyc=%0d got=%h@%h exp=%h@20", c, s_rdata, s_raddr, exp_d);
        end
      end
      step();
    end
    checks++; if (s_error !== 1'b0) begin failures++; $display("FAIL sw_error_clean got=%b exp=0", s_error); end
    s_read = 1; s_addr = 32'h10;
    step();
    s_read = 0;
    checks++; if (s_error !== 1'b1) begin failures++; $display("FAIL sw_misaligned got=%b exp=1", s_error); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_queue_full();
    test_protocol_errors();
    test_reset_mid_burst();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
